// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reconfiguration sequencer.
//   state_t  : sequencer FSM states
//   status_t : response codes returned to requesters
//   mnc_t    : one M/N/C setting
package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TRIG,
        WAIT_BUSY,
        WAIT_DONE,
        WAIT_LOCK,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OK        = 2'b00,
        SKIPPED   = 2'b01,
        BAD_PARAM = 2'b10,
        TIMEOUT   = 2'b11
    } status_t;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] n;
        logic [7:0] c;
    } mnc_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_seq_rr_arb.sv
// Two-way round-robin arbiter.
//   clock, reset_n : clock and synchronous active-low reset
//   req            : request bits of the two requesters
//   accept         : grant is taken this cycle; pointer moves past the winner
//   grant_any      : at least one request is pending
//   grant_idx      : index of the requester that wins this cycle
module pll_seq_rr_arb (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_any,
    output logic       grant_idx
);

    // Requester favoured on a tie; starts at 0 after reset.
    logic rr_reg;

    always_comb begin
        grant_any = |req;
        if (req == 2'b11) begin
            grant_idx = rr_reg;
        end else begin
            grant_idx = req[1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_reg <= 1'b0;
        end else if (accept && grant_any) begin
            rr_reg <= ~grant_idx;
        end
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Shares one reconfigurable PLL between two requesters. Requests are
// arbitrated round-robin, validated, sent to the PLL interface with a
// single trigger pulse, and tracked through busy and lock with timeouts.
//   clock, reset_n          : clock and synchronous active-low reset
//   req_valid/req_m/n/c     : per-requester request and settings (8 bits each)
//   rsp_valid/rsp_status    : one-cycle completion pulse and its status
//   trigger, pll_m/n/c      : reconfiguration start and settings to the PLL
//   busy, stable_reconfig   : reconfiguration busy and lock from the PLL
//   cur_m/n/c               : settings currently in force
//   clk_ready, fault        : clock usable / last reconfiguration timed out
module pll_reconfig_sequencer
    import pll_seq_pkg::*;
#(
    parameter int         BUSY_TIMEOUT = 1024,
    parameter int         LOCK_TIMEOUT = 65536,
    parameter int         LOCK_HOLD    = 16,
    parameter logic [7:0] RESET_M      = 8'd1,
    parameter logic [7:0] RESET_N      = 8'd1,
    parameter logic [7:0] RESET_C      = 8'd1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_m,
    input  logic [15:0] req_n,
    input  logic [15:0] req_c,
    output logic [1:0]  rsp_valid,
    output logic [1:0]  rsp_status,
    output logic        trigger,
    output logic [7:0]  pll_m,
    output logic [7:0]  pll_n,
    output logic [7:0]  pll_c,
    input  logic        busy,
    input  logic        stable_reconfig,
    output logic [7:0]  cur_m,
    output logic [7:0]  cur_n,
    output logic [7:0]  cur_c,
    output logic        clk_ready,
    output logic        fault
);

    localparam int TW = $clog2(max_int(BUSY_TIMEOUT, LOCK_TIMEOUT) + 1);
    localparam int HW = $clog2(LOCK_HOLD + 1);
    localparam logic [TW-1:0] BUSY_LIM = TW'(BUSY_TIMEOUT);
    localparam logic [TW-1:0] LOCK_LIM = TW'(LOCK_TIMEOUT);
    localparam logic [HW-1:0] HOLD_LIM = HW'(LOCK_HOLD);
    localparam mnc_t          RESET_MNC = '{m: RESET_M, n: RESET_N, c: RESET_C};

    state_t        state_reg;
    status_t       status_reg;
    logic          sel_reg;
    mnc_t          lat_reg;
    mnc_t          pll_reg;
    mnc_t          cur_reg;
    logic [1:0]    rsp_valid_reg;
    logic          trigger_reg;
    logic          fault_reg;
    logic [TW-1:0] timer_reg;
    logic [HW-1:0] hold_reg;

    mnc_t          req_vals [2];
    logic          arb_any;
    logic          arb_idx;
    logic          arb_accept;
    logic [TW-1:0] timer_inc;
    logic [HW-1:0] hold_next;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_vals[gi] = {req_m[8*gi +: 8], req_n[8*gi +: 8], req_c[8*gi +: 8]};
    end

    assign arb_accept = (state_reg == IDLE);

    pll_seq_rr_arb u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_valid),
        .accept    (arb_accept),
        .grant_any (arb_any),
        .grant_idx (arb_idx)
    );

    // Saturating timer increment; the limits are always below the ceiling.
    assign timer_inc = (&timer_reg) ? timer_reg : timer_reg + 1'b1;
    // Hold count including the current cycle's lock sample.
    assign hold_next = stable_reconfig ? hold_reg + 1'b1 : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            status_reg    <= OK;
            sel_reg       <= 1'b0;
            lat_reg       <= RESET_MNC;
            pll_reg       <= RESET_MNC;
            cur_reg       <= RESET_MNC;
            rsp_valid_reg <= 2'b00;
            trigger_reg   <= 1'b0;
            fault_reg     <= 1'b0;
            timer_reg     <= '0;
            hold_reg      <= '0;
        end else begin
            trigger_reg   <= 1'b0;
            rsp_valid_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        sel_reg   <= arb_idx;
                        lat_reg   <= req_vals[arb_idx];
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (lat_reg.m == 8'd0 || lat_reg.n == 8'd0 || lat_reg.c == 8'd0) begin
                        status_reg    <= BAD_PARAM;
                        rsp_valid_reg <= sel_reg ? 2'b10 : 2'b01;
                        state_reg     <= RESP;
                    end else if (lat_reg == cur_reg && !fault_reg) begin
                        // After a fault the PLL state is unknown, so no skipping.
                        status_reg    <= SKIPPED;
                        rsp_valid_reg <= sel_reg ? 2'b10 : 2'b01;
                        state_reg     <= RESP;
                    end else begin
                        pll_reg     <= lat_reg;
                        trigger_reg <= 1'b1;
                        state_reg   <= TRIG;
                    end
                end
                TRIG: begin
                    timer_reg <= '0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        timer_reg <= '0;
                        state_reg <= WAIT_DONE;
                    end else if (timer_reg == BUSY_LIM) begin
                        status_reg    <= TIMEOUT;
                        fault_reg     <= 1'b1;
                        rsp_valid_reg <= sel_reg ? 2'b10 : 2'b01;
                        state_reg     <= RESP;
                    end else begin
                        timer_reg <= timer_inc;
                    end
                end
                WAIT_DONE: begin
                    if (timer_reg == LOCK_LIM) begin
                        status_reg    <= TIMEOUT;
                        fault_reg     <= 1'b1;
                        rsp_valid_reg <= sel_reg ? 2'b10 : 2'b01;
                        state_reg     <= RESP;
                    end else begin
                        timer_reg <= timer_inc;
                        if (!busy) begin
                            hold_reg  <= '0;
                            state_reg <= WAIT_LOCK;
                        end
                    end
                end
                WAIT_LOCK: begin
                    // A completed lock hold wins over a timeout in the same cycle.
                    if (hold_next == HOLD_LIM) begin
                        status_reg    <= OK;
                        cur_reg       <= lat_reg;
                        fault_reg     <= 1'b0;
                        rsp_valid_reg <= sel_reg ? 2'b10 : 2'b01;
                        state_reg     <= RESP;
                    end else if (timer_reg == LOCK_LIM) begin
                        status_reg    <= TIMEOUT;
                        fault_reg     <= 1'b1;
                        rsp_valid_reg <= sel_reg ? 2'b10 : 2'b01;
                        state_reg     <= RESP;
                    end else begin
                        hold_reg  <= hold_next;
                        timer_reg <= timer_inc;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_status = status_reg;
    assign trigger    = trigger_reg;
    assign pll_m      = pll_reg.m;
    assign pll_n      = pll_reg.n;
    assign pll_c      = pll_reg.c;
    assign cur_m      = cur_reg.m;
    assign cur_n      = cur_reg.n;
    assign cur_c      = cur_reg.c;
    assign fault      = fault_reg;
    assign clk_ready  = stable_reconfig & (state_reg == IDLE) & ~fault_reg;

endmodule
